// File: rtl/ffe_pkg.sv
// Shared FFE definitions: writer/reader state encoding and default tap geometry.
// The read sequencer uses the same FFE_DEPTH so both sides agree on the tap count.
package ffe_pkg;

  localparam int FFE_DEPTH      = 4;
  localparam int FFE_COEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } ffe_state_t;

endpackage

// File: rtl/ffe_coeff_writer.sv
// Writer side of the FFE coefficient store: takes a DEPTH-beat burst and writes taps 0..DEPTH-1.
// Define FFE_COEFF_CHECKSUM_EN to expect one trailing checksum beat and report cfg_err.
module ffe_coeff_writer
  import ffe_pkg::*;
#(
  parameter int DEPTH      = FFE_DEPTH,
  parameter int ADDR_SIZE  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int COEF_WIDTH = FFE_COEF_WIDTH
) (
  input  logic                  ffe_clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic [COEF_WIDTH-1:0] cfg_data,
  output logic                  cfg_ready,
  input  logic                  ffe_active,
  output logic                  wr_en,
  output logic [ADDR_SIZE-1:0]  wr_addr,
  output logic [COEF_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  load_done,
  output logic                  cfg_err
);

  localparam int               CNT_W     = ADDR_SIZE + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);

  ffe_state_t       state;
  logic [CNT_W-1:0] beat_cnt;
  logic             beat_taken;

  // Holding ready low while the datapath reads is what keeps taps from tearing mid-convolution.
  assign cfg_ready  = ((state == LOAD) || (state == CHK)) && !ffe_active;
  assign beat_taken = cfg_valid && cfg_ready;

  always_ff @(posedge ffe_clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (beat_taken) begin
            wr_en    <= 1'b1;
            wr_addr  <= beat_cnt[ADDR_SIZE-1:0];
            wr_data  <= cfg_data;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
`ifdef FFE_COEFF_CHECKSUM_EN
              state <= CHK;
`else
              state     <= DONE;
              load_done <= 1'b1;
`endif
            end
          end
        end
        CHK: begin
`ifdef FFE_COEFF_CHECKSUM_EN
          if (beat_taken) begin
            state     <= DONE;
            load_done <= 1'b1;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          beat_cnt <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FFE_COEFF_CHECKSUM_EN
  logic [COEF_WIDTH-1:0] coef_sum;
  logic                  cfg_err_q;

  // Sum wraps mod 2^COEF_WIDTH; the error flag lives only for the DONE cycle.
  always_ff @(posedge ffe_clk) begin
    if (rst) begin
      coef_sum  <= '0;
      cfg_err_q <= 1'b0;
    end else if (state == DONE) begin
      coef_sum  <= '0;
      cfg_err_q <= 1'b0;
    end else if (beat_taken && (state == LOAD)) begin
      coef_sum <= coef_sum + cfg_data;
    end else if (beat_taken && (state == CHK)) begin
      cfg_err_q <= (cfg_data != coef_sum);
    end
  end

  assign cfg_err = cfg_err_q;
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_ffe_coeff_writer.sv
// Scoreboard bench for ffe_coeff_writer: randomized bursts, stalls and aborts against a burst-level model.
// Build with FFE_COEFF_CHECKSUM_EN defined to exercise the checksum beat.
module tb_ffe_coeff_writer;
  import ffe_pkg::*;

  localparam int DEPTH = FFE_DEPTH;
  localparam int CW    = FFE_COEF_WIDTH;
  localparam int AW    = $clog2(DEPTH);

  logic          ffe_clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [CW-1:0] cfg_data = '0;
  logic          ffe_active = 1'b0;
  logic          cfg_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          busy;
  logic          load_done;
  logic          cfg_err;

  ffe_coeff_writer dut (
    .ffe_clk   (ffe_clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .ffe_active(ffe_active),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .load_done (load_done),
    .cfg_err   (cfg_err)
  );

  always #5 ffe_clk = ~ffe_clk;

  int            checks = 0;
  int            failures = 0;
  int            done_seen = 0;
  bit            mon_en = 1'b0;
  int            exp_addr_q[$];
  logic [CW-1:0] exp_data_q[$];
  logic          exp_err_q[$];
  logic [CW-1:0] coef[DEPTH];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected write per wr_en and an expected result per load_done.
  always @(negedge ffe_clk) begin
    if (mon_en) begin
      if (ffe_active) checkOutput("ready_while_active", {31'd0, cfg_ready}, 32'd0);
      if (wr_en) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_write actual addr=%0d data=%0h required=no write", wr_addr, wr_data);
        end else begin
          int            ea;
          logic [CW-1:0] ed;
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          checkOutput("wr_addr", 32'(wr_addr), 32'(ea));
          checkOutput("wr_data", 32'(wr_data), 32'(ed));
        end
      end
      if (load_done) begin
        done_seen++;
        checks++;
        if (exp_err_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_load_done actual=1 required=0");
        end else begin
          logic ee;
          ee = exp_err_q.pop_front();
          checkOutput("cfg_err", {31'd0, cfg_err}, {31'd0, ee});
        end
`ifndef FFE_COEFF_CHECKSUM_EN
        checkOutput("done_with_last_write", {31'd0, wr_en}, 32'd1);
`endif
      end else begin
        checkOutput("cfg_err_without_done", {31'd0, cfg_err}, 32'd0);
      end
    end
  end

  // Drives one burst from coef[]; stall_mode 0=none, 1=random, 2=three cycles before beat 2.
  task automatic applyStimulus(input int abort_after, input bit mid_start, input int stall_mode,
                               input logic [CW-1:0] chk_beat);
    logic [CW-1:0] sum;
    int            nbeats;
    int            k;
    int            guard;
    int            hold;
    bit            held;
    int            d0;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) sum += coef[i];
`ifdef FFE_COEFF_CHECKSUM_EN
    nbeats = DEPTH + 1;
`else
    nbeats = DEPTH;
`endif
    k = 0; guard = 0; hold = 0; held = 1'b0;
    d0 = done_seen;
    @(posedge ffe_clk); #1;
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = coef[0]; ffe_active = 1'b0;
    @(negedge ffe_clk);
    checkOutput("ready_in_idle_with_start", {31'd0, cfg_ready}, 32'd0);
    @(posedge ffe_clk); #1;
    cfg_start = 1'b0;
    while (k < nbeats) begin
      if (stall_mode == 2 && k == 2 && !held) begin
        hold = 3;
        held = 1'b1;
      end
      if (stall_mode == 1) ffe_active = ($urandom_range(0, 3) == 0);
      else ffe_active = (hold > 0);
      if (hold > 0) hold--;
      cfg_valid = (stall_mode == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;
      cfg_data  = (k < DEPTH) ? coef[k] : chk_beat;
      cfg_start = (mid_start && k == 2);
      @(negedge ffe_clk);
      if (cfg_valid && cfg_ready) begin
        if (k < DEPTH) begin
          exp_addr_q.push_back(k);
          exp_data_q.push_back(coef[k]);
        end
        if (k == nbeats - 1) exp_err_q.push_back((k == DEPTH) ? (chk_beat != sum) : 1'b0);
        k++;
      end
      guard++;
      @(posedge ffe_clk); #1;
      if (guard > 200) begin
        failures++;
        $display("[TB] FAIL burst_timeout actual beats=%0d required=%0d", k, nbeats);
        break;
      end
      if (abort_after > 0 && k == abort_after) break;
    end
    cfg_valid = 1'b0; cfg_start = 1'b0; ffe_active = 1'b0;
    if (abort_after > 0) begin
      @(negedge ffe_clk);
      @(posedge ffe_clk); #1;
      rst = 1'b1;
      @(posedge ffe_clk); #1;
      rst = 1'b0;
      @(negedge ffe_clk);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_load_done", {31'd0, load_done}, 32'd0);
      checkOutput("abort_wr_en", {31'd0, wr_en}, 32'd0);
      checkOutput("abort_done_count", 32'(done_seen), 32'(d0));
    end else begin
      guard = 0;
      while (done_seen == d0 && guard < 20) begin
        @(posedge ffe_clk);
        guard++;
      end
      checks++;
      if (done_seen == d0) begin
        failures++;
        $display("[TB] FAIL load_done_timeout actual=none required=1 pulse");
      end
      #1;
      @(negedge ffe_clk);
      checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
      checkOutput("single_load_done", 32'(done_seen), 32'(d0 + 1));
    end
    checkOutput("pending_writes", 32'(exp_addr_q.size()), 32'd0);
    checkOutput("pending_done", 32'(exp_err_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [CW-1:0] good_sum;
    cfg_valid = 1'b1;
    repeat (2) @(posedge ffe_clk);
    #1 rst = 1'b0;
    @(negedge ffe_clk);
    checkOutput("reset_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset_wr_data", 32'(wr_data), 32'd0);
    checkOutput("reset_load_done", {31'd0, load_done}, 32'd0);
    checkOutput("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
    repeat (2) begin
      @(negedge ffe_clk);
      checkOutput("idle_ready_with_valid", {31'd0, cfg_ready}, 32'd0);
    end
    cfg_valid = 1'b0;
    mon_en = 1'b1;

    coef[0] = 8'h11; coef[1] = 8'h22; coef[2] = 8'h33; coef[3] = 8'h44;
    $display("[TB] back-to-back burst");
    applyStimulus(0, 1'b0, 0, 8'hAA);
    $display("[TB] ffe_active stall before beat 2");
    applyStimulus(0, 1'b0, 2, 8'hAA);
    $display("[TB] cfg_start while busy");
    applyStimulus(0, 1'b1, 0, 8'hAA);
    $display("[TB] checksum mismatch beat");
    applyStimulus(0, 1'b0, 0, 8'hAB);
    $display("[TB] reset after two beats");
    applyStimulus(2, 1'b0, 0, 8'hAA);
    coef[0] = 8'hA0; coef[1] = 8'hA1; coef[2] = 8'hA2; coef[3] = 8'hA3;
    applyStimulus(0, 1'b0, 0, 8'h86);

    $display("[TB] randomized bursts");
    for (int n = 0; n < 30; n++) begin
      good_sum = '0;
      for (int i = 0; i < DEPTH; i++) begin
        coef[i] = CW'($urandom_range(0, 255));
        good_sum += coef[i];
      end
      if ($urandom_range(0, 2) == 0) good_sum = good_sum ^ CW'($urandom_range(1, 255));
      applyStimulus((n % 7 == 6) ? int'($urandom_range(1, DEPTH - 1)) : 0,
                    ($urandom_range(0, 3) == 0), 1, good_sum);
    end

    repeat (3) @(posedge ffe_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
